cnn16_mem_ctrl: RTL and testbench
=================================

// Module: cnn16_mem_ctrl
// PURPOSE
//   Memory stage directly downstream of the CNN16 core's memory port. Serves the core's
//   read/write requests to a 4K x 16 on-chip word array, inserting programmable wait states
//   and returning mem_ready. A host load port preloads images and kernels while the core is idle.
// PARAMETERS
//   ADDR_W       12     address width; array depth = 2**ADDR_W words
//   DATA_W       16     word width
//   WAIT_CYCLES  2      wait states before each array access (0..15)
// PORTS
//   clk          in   1       system clock; all logic on rising edge
//   rst          in   1       synchronous, active-high reset
//   req          in   1       core request; held high until mem_ready
//   write_en     in   1       1 = write, 0 = read; sampled with req
//   address      in   ADDR_W  core word address; sampled with req
//   to_memory    in   DATA_W  core write data; sampled with req
//   from_memory  out  DATA_W  read data; valid while mem_ready=1, then held
//   mem_ready    out  1       one-cycle completion pulse (reads and writes)
//   host_we      in   1       host preload write strobe
//   host_addr    in   ADDR_W  host write address
//   host_wdata   in   DATA_W  host write data
//   host_busy    out  1       1 while a core transaction is in flight; host_we is ignored
//   parity_err   out  1       sticky read-parity error (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=IDLE, mem_ready=0, from_memory=0, host_busy=0, parity_err=0, wait counter=0.
//     Array contents are not cleared. Reset mid-transaction abandons it; a pending write is not performed.
//   FSM: IDLE -> WAIT -> ACCESS -> DONE -> IDLE.
//   IDLE: on req=1, latch write_en, address and to_memory, load cnt=WAIT_CYCLES, then go to WAIT.
//     If WAIT_CYCLES=0, go directly to ACCESS.
//   WAIT: decrement cnt each cycle; on the cycle cnt reaches 1, go to ACCESS.
//     The WAIT state lasts exactly WAIT_CYCLES cycles.
//   ACCESS: write the latched data to the array, or read array[addr] into from_memory. Go to DONE.
//   DONE: mem_ready=1 for exactly one cycle, then go to IDLE.
//   Latency: mem_ready is high WAIT_CYCLES+2 cycles after the accepting edge.
//     Back-to-back request spacing is WAIT_CYCLES+3 cycles.
//   Requester must drop req the cycle after mem_ready; a req still high in IDLE is treated as a new request.
//   Changes to address, write_en or to_memory after acceptance are ignored until the next IDLE.
//   host_busy = (state != IDLE), registered.
//   Host write is performed on the same edge when host_we=1 and state=IDLE.
//   Simultaneous host_we and req in IDLE: the host write takes effect and req is NOT accepted that cycle.
//     req is accepted on the next IDLE cycle with host_we=0. Host always wins.
//   host_we while busy: dropped silently; the host must gate host_we with host_busy.
//   from_memory changes only in ACCESS for reads; writes leave it unchanged.
//   Address wrap: none needed; the full ADDR_W range maps one-to-one onto the array.
// CONFIGURATION
//   CNN16_MEM_PARITY_EN defined:
//     - each word stores an even-parity bit, computed on both core and host writes;
//     - every read in ACCESS recomputes parity; a mismatch sets parity_err=1 (sticky until rst);
//     - read data is still returned and mem_ready timing is unchanged.
//   CNN16_MEM_PARITY_EN undefined: no parity storage; parity_err is tied to 0.
// STRUCTURE
//   Shared include cnn16_mem_defs.vh:
//     - state encodings S_IDLE=2'd0, S_WAIT=2'd1, S_ACCESS=2'd2, S_DONE=2'd3;
//     - default ADDR_W and DATA_W.
//   Sub-module cnn16_sram_1p: single-port synchronous array with
//     (clk, we, addr, wdata, rdata) and optional parity column.
//     Owns storage only; all arbitration and the FSM live in cnn16_mem_ctrl.
// TESTING
//   1. rst held 3 cycles mid-WAIT of a write to 0x010 -> mem_ready never pulses; read of 0x010 returns prior content.
//   2. WAIT_CYCLES=2; write 0xBEEF to 0x123, then read 0x123 -> mem_ready 4 cycles after acceptance; from_memory=0xBEEF.
//   3. Host writes 0x0001..0x0004 to 0x000..0x003; core reads 0x002 -> 0x0003.
//   4. host_we (0x050 <= 0x1111) and core read of 0x050 in the same IDLE cycle -> core accepted one cycle later; reads 0x1111.
//   5. host_we while host_busy=1 (addr 0x060 <= 0xAAAA) -> array[0x060] unchanged.
//   6. PARITY_EN: deposit an inverted parity bit at 0x070 and read it -> parity_err=1, held; cleared only by rst.
//      Without the macro the same read leaves parity_err=0.

Source files
------------

// File: rtl/cnn16_mem_ctrl_pkg.sv
// Shared definitions for the CNN16 memory stage: FSM encodings and default geometry.
// Used by cnn16_mem_ctrl and cnn16_sram_1p (optional parity via CNN16_MEM_PARITY_EN).
package cnn16_mem_ctrl_pkg;

    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Wait-state counts are limited to 0..15, so only the low nibble is kept.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
        return cycles[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/cnn16_sram_1p.sv
// Single-port synchronous word array for the CNN16 memory stage; storage only.
// With CNN16_MEM_PARITY_EN defined, an even-parity column is stored alongside each word.
module cnn16_sram_1p
    import cnn16_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef CNN16_MEM_PARITY_EN
    output logic              rpar,
`endif
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Registered read every cycle; a same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

`ifdef CNN16_MEM_PARITY_EN
    logic par_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[addr] <= ^wdata;
        end
        rpar <= par_mem[addr];
    end
`endif

endmodule

// File: rtl/cnn16_mem_ctrl.sv
// CNN16 memory stage: serves core requests with programmable wait states and a host preload port.
// Optional read-parity checking is enabled by defining CNN16_MEM_PARITY_EN.
module cnn16_mem_ctrl
    import cnn16_mem_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter int          DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] to_memory,
    output logic [DATA_W-1:0] from_memory,
    output logic              mem_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_busy,
    output logic              parity_err
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic              accept;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    // Host always wins in IDLE; a core request waits for a cycle without host_we.
    // In IDLE the array address follows the incoming request so that a zero-wait
    // access already has its word registered when ACCESS is reached.
    always_comb begin
        accept     = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = addr_q;
        sram_wdata = data_q;
        if (state == S_IDLE) begin
            accept     = req && !host_we;
            sram_we    = host_we;
            sram_addr  = host_we ? host_addr : address;
            sram_wdata = host_wdata;
        end else if (state == S_ACCESS) begin
            sram_we    = we_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mem_ready   <= 1'b0;
            from_memory <= '0;
            host_busy   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q      <= write_en;
                        addr_q    <= address;
                        data_q    <= to_memory;
                        cnt       <= CNT_LOAD;
                        host_busy <= 1'b1;
                        state     <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        from_memory <= sram_rdata;
                    end
                    mem_ready <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    host_busy <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    host_busy <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CNN16_MEM_PARITY_EN
    logic sram_rpar;
    logic par_err_q;

    // Sticky until reset; the read data is still delivered on a mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (state == S_ACCESS && !we_q && (sram_rpar != ^sram_rdata)) begin
            par_err_q <= 1'b1;
        end
    end

    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    cnn16_sram_1p #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (sram_wdata),
`ifdef CNN16_MEM_PARITY_EN
        .rpar  (sram_rpar),
`endif
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_cnn16_mem_ctrl.sv
// Directed self-checking bench for cnn16_mem_ctrl with WAIT_CYCLES=2.
// The parity scenario depends on CNN16_MEM_PARITY_EN.
module tb_cnn16_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        write_en = 1'b0;
    logic [11:0] address = '0;
    logic [15:0] to_memory = '0;
    logic [15:0] from_memory;
    logic        mem_ready;
    logic        host_we = 1'b0;
    logic [11:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_busy;
    logic        parity_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnn16_mem_ctrl #(
        .ADDR_W      (12),
        .DATA_W      (16),
        .WAIT_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .write_en    (write_en),
        .address     (address),
        .to_memory   (to_memory),
        .from_memory (from_memory),
        .mem_ready   (mem_ready),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_busy   (host_busy),
        .parity_err  (parity_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic hostWrite(input logic [11:0] addr, input logic [15:0] data);
        @(negedge clk);
        host_we    = 1'b1;
        host_addr  = addr;
        host_wdata = data;
        @(negedge clk);
        host_we    = 1'b0;
    endtask

    // Counts negedges after the accepting edge until mem_ready; drops req in the DONE cycle.
    task automatic waitReady(output int lat, output logic [15:0] data);
        bit done = 1'b0;
        int n = 0;
        data = '0;
        while (!done && n < 32) begin
            @(negedge clk);
            n++;
            if (mem_ready) begin
                done = 1'b1;
                data = from_memory;
                req  = 1'b0;
            end
        end
        req = 1'b0;
        lat = n;
        checkOutput("ready_timeout", 32'(done), 32'd1);
    endtask

    task automatic applyStimulus(input logic we, input logic [11:0] addr,
                                 input logic [15:0] data, output int lat,
                                 output logic [15:0] rd);
        @(negedge clk);
        req       = 1'b1;
        write_en  = we;
        address   = addr;
        to_memory = data;
        @(posedge clk);
        waitReady(lat, rd);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        bit          seen;

        applyReset(3);
        checkOutput("rst_mem_ready", 32'(mem_ready), 32'd0);
        checkOutput("rst_from_memory", 32'(from_memory), 32'h0);
        checkOutput("rst_host_busy", 32'(host_busy), 32'd0);
        checkOutput("rst_parity_err", 32'(parity_err), 32'd0);

        // Write then read back 0x123: ready in cycle WAIT_CYCLES+2 after acceptance.
        applyStimulus(1'b1, 12'h123, 16'hBEEF, lat, rd);
        checkOutput("wr_latency", 32'(lat), 32'd4);
        checkOutput("wr_keeps_from_memory", 32'(rd), 32'h0);
        applyStimulus(1'b0, 12'h123, 16'h0000, lat, rd);
        checkOutput("rd_latency", 32'(lat), 32'd4);
        checkOutput("rd_data_beef", 32'(rd), 32'hBEEF);
        @(negedge clk);
        checkOutput("rd_data_held", 32'(from_memory), 32'hBEEF);
        checkOutput("ready_one_cycle", 32'(mem_ready), 32'd0);
        checkOutput("busy_after_done", 32'(host_busy), 32'd0);

        // Host preload then core read.
        for (int i = 0; i < 4; i++) hostWrite(12'(i), 16'(i + 1));
        applyStimulus(1'b0, 12'h002, 16'h0000, lat, rd);
        checkOutput("host_preload_read", 32'(rd), 32'h0003);
        checkOutput("host_preload_lat", 32'(lat), 32'd4);

        // Simultaneous host_we and req: host write first, request accepted a cycle later.
        @(negedge clk);
        host_we    = 1'b1;
        host_addr  = 12'h050;
        host_wdata = 16'h1111;
        req        = 1'b1;
        write_en   = 1'b0;
        address    = 12'h050;
        @(negedge clk);
        checkOutput("host_wins_not_busy", 32'(host_busy), 32'd0);
        host_we = 1'b0;
        @(posedge clk);
        waitReady(lat, rd);
        checkOutput("host_wins_lat", 32'(lat), 32'd4);
        checkOutput("host_wins_data", 32'(rd), 32'h1111);

        // host_we while busy is dropped.
        hostWrite(12'h060, 16'h5555);
        @(negedge clk);
        req      = 1'b1;
        write_en = 1'b0;
        address  = 12'h123;
        @(negedge clk);
        checkOutput("busy_during_txn", 32'(host_busy), 32'd1);
        host_we    = 1'b1;
        host_addr  = 12'h060;
        host_wdata = 16'hAAAA;
        @(negedge clk);
        host_we = 1'b0;
        waitReady(lat, rd);
        checkOutput("busy_txn_data", 32'(rd), 32'hBEEF);
        applyStimulus(1'b0, 12'h060, 16'h0000, lat, rd);
        checkOutput("busy_host_dropped", 32'(rd), 32'h5555);

        // Reset mid-WAIT abandons a pending write.
        hostWrite(12'h010, 16'h5A5A);
        @(negedge clk);
        req       = 1'b1;
        write_en  = 1'b1;
        address   = 12'h010;
        to_memory = 16'hDEAD;
        @(negedge clk);
        rst  = 1'b1;
        req  = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= mem_ready;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= mem_ready;
        end
        checkOutput("midwait_no_ready", 32'(seen), 32'd0);
        checkOutput("midwait_busy", 32'(host_busy), 32'd0);
        checkOutput("midwait_from_memory", 32'(from_memory), 32'h0);
        applyStimulus(1'b0, 12'h010, 16'h0000, lat, rd);
        checkOutput("midwait_prior_content", 32'(rd), 32'h5A5A);

        // Parity: corrupted parity bit at 0x070.
        hostWrite(12'h070, 16'h00FF);
`ifdef CNN16_MEM_PARITY_EN
        @(negedge clk);
        dut.u_sram.par_mem[12'h070] = 1'b1;
        applyStimulus(1'b0, 12'h070, 16'h0000, lat, rd);
        checkOutput("parity_data", 32'(rd), 32'h00FF);
        @(negedge clk);
        checkOutput("parity_err_set", 32'(parity_err), 32'd1);
        applyStimulus(1'b0, 12'h010, 16'h0000, lat, rd);
        checkOutput("parity_err_sticky", 32'(parity_err), 32'd1);
        applyReset(2);
        checkOutput("parity_err_cleared", 32'(parity_err), 32'd0);
`else
        applyStimulus(1'b0, 12'h070, 16'h0000, lat, rd);
        checkOutput("parity_data", 32'(rd), 32'h00FF);
        @(negedge clk);
        checkOutput("parity_err_tied", 32'(parity_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
